psum_arb: RTL
=============

PSUM_ARB -- requirements
Module: psum_arb

Interface
REQ-001 Parameter: NUM_PORT, 4, number of MAC write ports arbitrated.
REQ-002 Parameter: PSUM_ADDR_WIDTH, 4, psum row address width (LENROW = 16).
REQ-003 Parameter: PSUM_WIDTH, 23, psum data width.
REQ-004 Parameter: W = PSUM_ADDR_WIDTH+PSUM_WIDTH, derived, packed entry width {data, addr}, addr in LSBs.
REQ-005 clk  input  1  clock, all state on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 clr  input  1  synchronous abort; returns block to IDLE.
REQ-008 start  input  1  single-cycle tile-start pulse.
REQ-009 psum_empty  input  1  downstream psum buffer idle (high when it is in IDLE).
REQ-010 mac_val  input  NUM_PORT  per-port entry valid.
REQ-011 mac_data  input  NUM_PORT*W  per-port entry, port i at [i*W +: W].
REQ-012 mac_rdy  output  NUM_PORT  per-port accept, one-hot or zero.
REQ-013 mac_fnh  input  NUM_PORT  per-port pulse: port has no further entries this tile.
REQ-014 psumaddr_val  output  1  output entry valid (registered).
REQ-015 psumaddr  output  W  output entry (registered).
REQ-016 psumaddr_rdy  input  1  downstream accepts entry.
REQ-017 arb_fnh  output  1  high whenever state is not RUN.
REQ-018 mac_empty  output  1  high when the output register holds no entry.
REQ-019 tile_cnt  output  16  entries forwarded in current tile.
REQ-020 proto_err  output  1  sticky protocol-violation flag.

Function
REQ-021 FSM states IDLE, RUN, DRAIN; encoded in 2 bits.
REQ-022 IDLE -> RUN on start=1 and psum_empty=1; start in any other state or with psum_empty=0 is ignored.
REQ-023 On IDLE -> RUN: done[] cleared, tile_cnt cleared to 0, round-robin pointer kept.
REQ-024 RUN: done[i] set sticky on mac_fnh[i]=1; mac_fnh in IDLE/DRAIN ignored.
REQ-025 RUN -> DRAIN when all done[] set (including bits set this cycle) and no mac_val asserted.
REQ-026 DRAIN -> IDLE when output register empty, or in the cycle its entry is accepted.
REQ-027 Output register loadable ("load_ok") when empty or psumaddr_val and psumaddr_rdy both high this cycle.
REQ-028 Grant only in RUN with load_ok: first port with mac_val set, searching from pointer upward with wrap from NUM_PORT-1 to 0.
REQ-029 mac_rdy = one-hot grant, combinational from mac_val, pointer, state, psumaddr_rdy; zero otherwise.
REQ-030 On accept of port g: register loads mac_data of port g next edge, pointer := (g+1) mod NUM_PORT, tile_cnt increments, saturating at 0xFFFF.
REQ-031 Simultaneous downstream accept and new grant: register replaced, psumaddr_val stays 1, zero-bubble throughput of one entry per cycle.
REQ-032 Accept without new grant: psumaddr_val falls next edge.
REQ-033 psumaddr and psumaddr_val stable while psumaddr_val=1 and psumaddr_rdy=0.
REQ-034 mac_empty = ~psumaddr_val; arb_fnh = (state != RUN).
REQ-035 mac_val[i]=1 while done[i]=1 in RUN: sets proto_err, entry still served.
REQ-036 mac_fnh[i] and mac_val[i] in same cycle: entry served, done[i] set; legal.
REQ-037 clr (any state): next edge state=IDLE, psumaddr_val=0, done[]=0, mac_rdy=0 during clr cycle; tile_cnt and proto_err hold; clr has priority over start.

Reset
REQ-038 rst_n low: state=IDLE, psumaddr_val=0, psumaddr=0, mac_rdy=0, done[]=0, pointer=0, tile_cnt=0, proto_err=0; hence arb_fnh=1, mac_empty=1.
REQ-039 Reset assertion mid-tile drops any held entry without handshake.

Verification
REQ-040 Reset then start with psum_empty=1 -> arb_fnh 1 to 0 next edge; start with psum_empty=0 -> stays IDLE.
REQ-041 All 4 ports val continuously, psumaddr_rdy=1 -> grants 0,1,2,3,0,... one per cycle, psumaddr_val stays high, tile_cnt=8 after 8 beats.
REQ-042 Port 2 entry {data=5, addr=3}, psumaddr_rdy low 3 cycles -> psumaddr holds value 5<<4|3 stable, mac_rdy=0 for all ports until accept.
REQ-043 mac_fnh on ports 0..3 over cycles, last entry pending in register -> DRAIN until accepted, then IDLE, arb_fnh=1.
REQ-044 Port 1 val after its fnh -> proto_err=1, entry forwarded; clr mid-RUN with entry held -> IDLE, psumaddr_val=0 next edge.

Source files
------------

// File: rtl/psum_arb_if.sv
// psum_arb_if -- handshake bundle between the MAC write ports, the psum
// arbiter and the downstream psum buffer.
//
// Signals:
//   mac_val   [NUM_PORT]    per-port entry valid (MAC side drives)
//   mac_data  [NUM_PORT*W]  per-port entry {data, addr}, port i at [i*W +: W]
//   mac_rdy   [NUM_PORT]    per-port accept, one-hot or zero (arbiter drives)
//   mac_fnh   [NUM_PORT]    per-port "no more entries this tile" pulse
//   psumaddr_val            output entry valid (arbiter drives)
//   psumaddr  [W]           output entry (arbiter drives)
//   psumaddr_rdy            downstream accepts entry
//
// Modports:
//   master -- the MAC / downstream environment around the arbiter
//   slave  -- the arbiter itself
interface psum_arb_if #(
  parameter int NUM_PORT = 4,
  parameter int W        = 27
);
  logic [NUM_PORT-1:0]   mac_val;
  logic [NUM_PORT*W-1:0] mac_data;
  logic [NUM_PORT-1:0]   mac_rdy;
  logic [NUM_PORT-1:0]   mac_fnh;
  logic                  psumaddr_val;
  logic [W-1:0]          psumaddr;
  logic                  psumaddr_rdy;

  modport master (
    output mac_val, mac_data, mac_fnh, psumaddr_rdy,
    input  mac_rdy, psumaddr_val, psumaddr
  );

  modport slave (
    input  mac_val, mac_data, mac_fnh, psumaddr_rdy,
    output mac_rdy, psumaddr_val, psumaddr
  );
endinterface

// File: rtl/psum_arb.sv
// psum_arb -- round-robin arbiter funnelling NUM_PORT MAC write ports into a
// single registered psum entry stream, with per-tile start/finish tracking.
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   clr             synchronous abort back to IDLE (priority over start)
//   start           single-cycle tile-start pulse
//   psum_empty      downstream psum buffer is idle
//   bus             psum_arb_if.slave: MAC val/data/rdy/fnh and output
//                   psumaddr_val/psumaddr/psumaddr_rdy
//   arb_fnh         high whenever the arbiter is not in RUN
//   mac_empty       high when the output register holds no entry
//   tile_cnt[16]    entries forwarded in the current tile (saturating)
//   proto_err       sticky: a port presented an entry after its finish pulse
module psum_arb #(
  parameter int NUM_PORT        = 4,
  parameter int PSUM_ADDR_WIDTH = 4,
  parameter int PSUM_WIDTH      = 23,
  parameter int W               = PSUM_ADDR_WIDTH + PSUM_WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        start,
  input  logic        psum_empty,
  psum_arb_if.slave   bus,
  output logic        arb_fnh,
  output logic        mac_empty,
  output logic [15:0] tile_cnt,
  output logic        proto_err
);

  localparam int PTR_W = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state;
  logic [NUM_PORT-1:0] done;
  logic [PTR_W-1:0]    ptr;
  logic                out_val;
  logic [W-1:0]        out_data;

  logic                load_ok;
  logic                grant_any;
  logic [NUM_PORT-1:0] grant;
  logic [PTR_W-1:0]    grant_idx;
  logic [PTR_W-1:0]    next_ptr;
  logic [PTR_W:0]      cand;
  logic [PTR_W-1:0]    cand_idx;
  logic [NUM_PORT-1:0] done_upd;
  logic [W-1:0]        port_data [NUM_PORT];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORT; gi++) begin : g_unpack
      assign port_data[gi] = bus.mac_data[gi*W +: W];
    end
  endgenerate

  // The register can take a new entry when empty, or when its current entry
  // leaves this very cycle (zero-bubble back-to-back transfer).
  assign load_ok = ~out_val | bus.psumaddr_rdy;

  // Round-robin search starting at ptr; the first valid port wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    cand_idx  = '0;
    if (state == RUN && load_ok && !clr) begin
      for (int k = 0; k < NUM_PORT; k++) begin
        cand = {1'b0, ptr} + (PTR_W+1)'(k);
        if (cand >= (PTR_W+1)'(NUM_PORT)) begin
          cand = cand - (PTR_W+1)'(NUM_PORT);
        end
        cand_idx = cand[PTR_W-1:0];
        if (!grant_any && bus.mac_val[cand_idx]) begin
          grant_any       = 1'b1;
          grant_idx       = cand_idx;
          grant[cand_idx] = 1'b1;
        end
      end
    end
  end

  assign next_ptr = (grant_idx == PTR_W'(NUM_PORT-1)) ? '0 : grant_idx + 1'b1;

  // Finish pulses seen this cycle count toward the RUN -> DRAIN decision.
  assign done_upd = done | bus.mac_fnh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      done      <= '0;
      ptr       <= '0;
      out_val   <= 1'b0;
      out_data  <= '0;
      tile_cnt  <= '0;
      proto_err <= 1'b0;
    end else if (clr) begin
      // Abort drops any held entry; counters and the error flag are kept.
      state   <= IDLE;
      out_val <= 1'b0;
      done    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && psum_empty) begin
            state    <= RUN;
            done     <= '0;
            tile_cnt <= '0;
          end
        end
        RUN: begin
          done <= done_upd;
          // Compare against the finish bits from earlier cycles only, so an
          // entry arriving together with its own finish pulse is legal.
          if (|(bus.mac_val & done)) begin
            proto_err <= 1'b1;
          end
          if ((&done_upd) && !(|bus.mac_val)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (load_ok) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Grants only occur in RUN, so this never collides with the IDLE clear.
      if (grant_any) begin
        out_val  <= 1'b1;
        out_data <= port_data[grant_idx];
        ptr      <= next_ptr;
        if (tile_cnt != 16'hFFFF) begin
          tile_cnt <= tile_cnt + 16'd1;
        end
      end else if (out_val && bus.psumaddr_rdy) begin
        out_val <= 1'b0;
      end
    end
  end

  assign bus.mac_rdy      = grant;
  assign bus.psumaddr_val = out_val;
  assign bus.psumaddr     = out_data;
  assign arb_fnh          = (state != RUN);
  assign mac_empty        = ~out_val;

endmodule
